safe: RTL and testbench

Keypad-driven digital safe controller. Decodes an externally scanned 4×3 keypad (1-9 / 0 / * / #), manages password entry, verification with three attempts, lockout and password change, and exports a 3-bit state code and a 6-LED entry-progress bar. It sits under the board top level, which drives the one-hot row scan and renders `state` on LEDs and 7-segment displays.

---
 rtl/safe_pkg.sv | 25 ++
 rtl/safe_if.sv | 12 +
 rtl/safe_keypad.sv | 54 +++++
 rtl/safe.sv | 86 ++++++++
 tb/tb_safe.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/safe_pkg.sv
// safe_pkg: shared state codes, key codes, and password constants for the safe controller.
package safe_pkg;
   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_ON     = 3'd1,
      S_WRONG1 = 3'd2,
      S_WRONG2 = 3'd3,
      S_OPEN   = 3'd4,
      S_RESET  = 3'd5,
      S_LOCK   = 3'd7
   } state_t;
   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_SHARP = 4'd11;
   localparam int MAX_DIGITS = 6;
   typedef logic [MAX_DIGITS-1:0][3:0] digits_t;
   // Unused digit slots stay zero, so whole-vector equality plus length equality is an exact match.
   localparam digits_t DEF_PW = {4'd0, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1};
   localparam logic [2:0] DEF_LEN = 3'd4;
   // Bitmap index r*3+c maps to the key code of row r, column c.
   localparam logic [11:0][3:0] KEY_MAP = {KEY_SHARP, 4'd0, KEY_STAR, 4'd9, 4'd8, 4'd7,
                                           4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
   function automatic logic [5:0] therm(input logic [2:0] n);
      return ~(6'b111111 >> n);
   endfunction
endpackage

// File: rtl/safe_if.sv
// safe_if: keypad scan, password-change button, and status outputs of the safe.
interface safe_if;
   logic row1, row2, row3, row4;
   logic col1, col2, col3;
   logic reset_password;
   logic [5:0] password_led;
   logic [2:0] state;
   modport master(output row1, row2, row3, row4, col1, col2, col3, reset_password,
                  input password_led, state);
   modport slave(input row1, row2, row3, row4, col1, col2, col3, reset_password,
                 output password_led, state);
endinterface

// File: rtl/safe_keypad.sv
// safe_keypad: synchronises the scanned keypad into a held key bitmap and emits one event per press.
module safe_keypad
   import safe_pkg::*;
(
   input  logic       clk,
   input  logic       initialize,
   input  logic [3:0] row,
   input  logic [2:0] col,
   input  logic       reset_password,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       rp_event
);
   logic [3:0] row_a, row_s;
   logic [2:0] col_a, col_s;
   logic rp_a, rp_s, rp_q;
   logic [11:0] bm, bm_n, rise;
   logic [3:0] idx;
   always_ff @(posedge clk) begin
      if (initialize) begin
         row_a <= '0;
         row_s <= '0;
         col_a <= '0;
         col_s <= '0;
         rp_a  <= 1'b0;
         rp_s  <= 1'b0;
         rp_q  <= 1'b0;
         bm    <= '0;
      end else begin
         row_a <= row;
         row_s <= row_a;
         col_a <= col;
         col_s <= col_a;
         rp_a  <= reset_password;
         rp_s  <= rp_a;
         rp_q  <= rp_s;
         bm    <= bm_n;
      end
   end
   // Rows not being strobed keep their bits, so leaving a row slot never looks like a release.
   always_comb begin
      bm_n = bm;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (row_s[r]) bm_n[r*3+c] = col_s[c];
      rise = bm_n & ~bm;
      idx = '0;
      for (int i = 11; i >= 0; i--)
         if (rise[i]) idx = 4'(i);
   end
   assign key_valid = |rise;
   assign key_code = KEY_MAP[idx];
   assign rp_event = rp_s & ~rp_q;
endmodule

// File: rtl/safe.sv
// safe: keypad safe controller with three tries, lockout, and password change.
module safe
   import safe_pkg::*;
(
   input  logic clk,
   input  logic initialize,
   safe_if.slave bus
);
   state_t st, st_n;
   digits_t entry, entry_n, pw, pw_n;
   logic [2:0] cnt, cnt_n, len, len_n;
   logic key_valid, rp_event, digit, star, sharp, editing, match, clr;
   logic [3:0] key_code;
   safe_keypad u_keypad (
      .clk(clk),
      .initialize(initialize),
      .row({bus.row4, bus.row3, bus.row2, bus.row1}),
      .col({bus.col3, bus.col2, bus.col1}),
      .reset_password(bus.reset_password),
      .key_valid(key_valid),
      .key_code(key_code),
      .rp_event(rp_event)
   );
   assign digit = key_valid && key_code < 4'd10;
   assign star = key_valid && key_code == KEY_STAR;
   assign sharp = key_valid && key_code == KEY_SHARP;
   assign editing = st inside {S_ON, S_WRONG1, S_WRONG2, S_RESET};
   assign match = cnt == len && entry == pw;
   always_ff @(posedge clk) begin
      if (initialize) begin
         st    <= S_OFF;
         entry <= '0;
         cnt   <= '0;
         pw    <= DEF_PW;
         len   <= DEF_LEN;
      end else begin
         st    <= st_n;
         entry <= entry_n;
         cnt   <= cnt_n;
         pw    <= pw_n;
         len   <= len_n;
      end
   end
   always_comb begin
      st_n = st;
      entry_n = entry;
      cnt_n = cnt;
      pw_n = pw;
      len_n = len;
      clr = 1'b0;
      if (editing && digit && cnt < 3'(MAX_DIGITS)) begin
         entry_n[cnt] = key_code;
         cnt_n = cnt + 3'd1;
      end
      case (st)
         S_OFF: if (sharp) begin
            st_n = S_ON;
            clr = 1'b1;
         end
         S_ON, S_WRONG1, S_WRONG2: if (sharp) begin
            st_n = match ? S_OPEN : st == S_ON ? S_WRONG1 : st == S_WRONG1 ? S_WRONG2 : S_LOCK;
            clr = 1'b1;
         end
         S_OPEN: if (rp_event) begin
            st_n = S_RESET;
            clr = 1'b1;
         end else if (sharp) begin
            st_n = S_ON;
            clr = 1'b1;
         end
         S_RESET: if (sharp && cnt != 3'd0) begin
            pw_n = entry;
            len_n = cnt;
            st_n = S_ON;
            clr = 1'b1;
         end
         default: ;
      endcase
      if (clr || (editing && star)) begin
         entry_n = '0;
         cnt_n = '0;
      end
   end
   assign bus.state = st;
   assign bus.password_led = st inside {S_OFF, S_OPEN, S_LOCK} ? 6'd0 : therm(cnt);
endmodule

// File: tb/tb_safe.sv
// tb_safe: directed keypad sequences checked every cycle against a queue-based model of the safe.
module tb_safe;
   logic clk = 1'b0;
   logic initialize = 1'b0;
   safe_if bus();
   safe dut(.clk(clk), .initialize(initialize), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {int due; int kind; int key;} ev_t;
   ev_t ev[$];
   int cyc = 0, n_chk = 0, n_fail = 0, ms = 0;
   int entry[$], pw[$];
   bit started = 1'b0;

   task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic bit same_pw();
      if (entry.size() != pw.size()) return 1'b0;
      foreach (entry[i]) if (entry[i] != pw[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [5:0] exp_led();
      logic [5:0] l = '0;
      if (ms inside {1, 2, 3, 5})
         for (int i = 0; i < entry.size(); i++) l[5-i] = 1'b1;
      return l;
   endfunction

   task automatic apply_key(input int k);
      if (ms == 0 || ms == 4) begin
         if (k == 11) begin ms = 1; entry.delete(); end
      end else if (ms inside {1, 2, 3, 5}) begin
         if (k < 10) begin
            if (entry.size() < 6) entry.push_back(k);
         end else if (k == 10) entry.delete();
         else if (ms == 5) begin
            if (entry.size() > 0) begin pw = entry; entry.delete(); ms = 1; end
         end else begin
            ms = same_pw() ? 4 : (ms == 3 ? 7 : ms + 1);
            entry.delete();
         end
      end
   endtask

   always @(posedge clk) begin : model
      bit do_init, do_rp;
      int key;
      cyc++;
      do_init = 1'b0;
      do_rp = 1'b0;
      key = -1;
      while (ev.size() > 0 && ev[0].due == cyc) begin
         if (ev[0].kind == 2) do_init = 1'b1;
         else if (ev[0].kind == 1) do_rp = 1'b1;
         else key = ev[0].key;
         void'(ev.pop_front());
      end
      if (do_init) begin
         ms = 0;
         entry.delete();
         pw = '{1, 2, 3, 4};
         started = 1'b1;
      end else if (do_rp && ms == 4) begin
         ms = 5;
         entry.delete();
      end else if (key >= 0) apply_key(key);
   end

   always @(negedge clk) begin
      if (started) begin
         chk("state", 6'(bus.state), 6'(ms));
         chk("password_led", bus.password_led, exp_led());
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int r, input int c);
      bus.row1 = (r == 0); bus.row2 = (r == 1); bus.row3 = (r == 2); bus.row4 = (r == 3);
      bus.col1 = (c == 0); bus.col2 = (c == 1); bus.col3 = (c == 2);
   endtask

   task automatic push(input int kind, input int key, input int lat);
      ev.push_back('{cyc + lat, kind, key});
   endtask

   task automatic press(input int k, input bit with_rp = 1'b0);
      int r, c;
      if (k >= 1 && k <= 9) begin r = (k - 1) / 3; c = (k - 1) % 3; end
      else begin r = 3; c = (k == 10) ? 0 : (k == 0) ? 1 : 2; end
      drive(r, c);
      bus.reset_password = with_rp;
      push(0, k, 3);
      if (with_rp) push(1, 0, 3);
      tick(5);
      drive(r, -1);
      bus.reset_password = 1'b0;
      tick(5);
      drive(-1, -1);
      tick(1);
   endtask

   task automatic keys(input int ks[$]);
      foreach (ks[i]) press(ks[i]);
   endtask

   task automatic rp_pulse();
      bus.reset_password = 1'b1;
      push(1, 0, 3);
      tick(5);
      bus.reset_password = 1'b0;
      tick(5);
   endtask

   task automatic do_init();
      initialize = 1'b1;
      push(2, 0, 1);
      tick(3);
      initialize = 1'b0;
      tick(2);
   endtask

   task automatic hold_five();
      for (int s = 0; s < 3; s++)
         for (int r = 0; r < 4; r++) begin
            drive(r, r == 1 ? 1 : -1);
            if (s == 0 && r == 1) push(0, 5, 3);
            tick(5);
         end
      drive(1, -1);
      tick(5);
      drive(-1, -1);
      tick(1);
   endtask

   initial begin
      drive(-1, -1);
      bus.reset_password = 1'b0;
      tick(2);
      do_init();
      chk("reset_state", 6'(bus.state), 6'd0);
      chk("reset_led", bus.password_led, 6'b000000);
      press(11);
      chk("on_state", 6'(bus.state), 6'd1);
      press(1);
      chk("first_digit_led", bus.password_led, 6'b100000);
      keys('{2, 3, 4});
      chk("four_digit_led", bus.password_led, 6'b111100);
      press(11);
      chk("unlock_state", 6'(bus.state), 6'd4);
      chk("open_led", bus.password_led, 6'b000000);
      press(11);
      keys('{9, 11});
      chk("wrong1_state", 6'(bus.state), 6'd2);
      keys('{9, 11});
      chk("wrong2_state", 6'(bus.state), 6'd3);
      keys('{9, 11});
      chk("lock_state", 6'(bus.state), 6'd7);
      keys('{1, 2, 3, 4, 11});
      chk("lock_holds", 6'(bus.state), 6'd7);
      chk("lock_led", bus.password_led, 6'b000000);
      do_init();
      chk("unlock_reset_state", 6'(bus.state), 6'd0);
      keys('{11, 1, 2, 3, 4, 11});
      rp_pulse();
      chk("reset_mode_state", 6'(bus.state), 6'd5);
      keys('{5, 6, 11});
      chk("new_pw_state", 6'(bus.state), 6'd1);
      keys('{1, 2, 3, 4, 11});
      chk("old_pw_rejected", 6'(bus.state), 6'd2);
      keys('{5, 6, 11});
      chk("new_pw_opens", 6'(bus.state), 6'd4);
      rp_pulse();
      keys('{1, 2, 3, 4, 5, 6, 7});
      chk("seven_digits_led", bus.password_led, 6'b111111);
      press(10);
      chk("star_clears_led", bus.password_led, 6'b000000);
      press(11);
      chk("empty_sharp_in_reset", 6'(bus.state), 6'd5);
      keys('{7, 11});
      press(11);
      chk("empty_sharp_wrong", 6'(bus.state), 6'd2);
      hold_five();
      chk("held_key_led", bus.password_led, 6'b100000);
      press(11);
      chk("held_key_wrong2", 6'(bus.state), 6'd3);
      keys('{7, 11});
      rp_pulse();
      press(8);
      chk("mid_entry_led", bus.password_led, 6'b100000);
      do_init();
      chk("mid_entry_reset", 6'(bus.state), 6'd0);
      keys('{11, 1, 2, 3, 4, 11});
      chk("default_pw_restored", 6'(bus.state), 6'd4);
      press(11, 1'b1);
      chk("rp_beats_key", 6'(bus.state), 6'd5);
      press(11);
      keys('{1, 2, 3, 4, 11});
      chk("stored_after_priority", 6'(bus.state), 6'd1);
      rp_pulse();
      chk("rp_ignored_outside_open", 6'(bus.state), 6'd1);
      tick(4);
      chk("events_drained", 6'(ev.size()), 6'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
